// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the Thumb core.
//   REG_SP / REG_LR / REG_PC : architectural indices of the high registers
//   WORD_BYTES               : byte stride between consecutive words
//   pop_state_t              : state encoding of the POP/LDMIA sequencer
package regfile_pkg;

  localparam logic [3:0] REG_SP = 4'hd;
  localparam logic [3:0] REG_LR = 4'he;
  localparam logic [3:0] REG_PC = 4'hf;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } pop_state_t;

endpackage

// File: rtl/lsb_enc.sv
// Lowest-set-bit encoder.
//   vec   : input bit vector (N bits)
//   idx   : index of the lowest set bit (0 when vec is all zero)
//   valid : 1 when at least one bit of vec is set
module lsb_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so that the lowest set bit is the last one
  // written and therefore wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pop_sequencer.sv
// POP / LDMIA multi-register load sequencer.
//
// Walks the latched register list lowest-first, issues one word read per
// register on the data-memory port and drives the register-file write port
// one cycle after each read completes. An optional PC load follows the low
// registers, and the final address can be written back through the SP port.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   start_i             : one-cycle request, accepted only while idle
//   reg_list_i          : bitmap of low registers (r0..r{NREGS-1})
//   pc_bit_i            : also load PC after the low registers
//   base_i              : start address (bits [1:0] forced to 0)
//   sp_update_i         : write the final address back via the SP port
//   mem_req_o/addr_o    : word read request to data memory
//   mem_ack_i/rdata_i   : read completion and data
//   write_en_o, wr_select_o, data_o : register-file write port
//   sp_write_en_o, sp_o : SP writeback port
//   pc_we_o, pc_o       : PC load to fetch
//   busy_o              : sequencer occupied (pipeline stall)
//   done_o              : one-cycle completion pulse
//   state_o             : current FSM state (debug)
//
// Memory handshake: mem_req_o rises with mem_addr_o valid and both stay
// unchanged until the cycle in which mem_ack_i=1; that cycle completes the
// beat and mem_rdata_i is valid in it. A new request may start the very next
// cycle. An ack seen while no request is outstanding is ignored.
module pop_sequencer
  import regfile_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NREGS-1:0] reg_list_i,
  input  logic             pc_bit_i,
  input  logic [31:0]      base_i,
  input  logic             sp_update_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             write_en_o,
  output logic [3:0]       wr_select_o,
  output logic [31:0]      data_o,
  output logic             sp_write_en_o,
  output logic [31:0]      sp_o,
  output logic             pc_we_o,
  output logic [31:0]      pc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(NREGS + 2);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [NREGS-1:0] LIST_ONE = NREGS'(1);

  // Sequencer state
  pop_state_t       state_q, state_d;
  logic [NREGS-1:0] list_q, list_d;
  logic             pc_pend_q, pc_pend_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      base_q, base_d;
  logic             sp_upd_q, sp_upd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Registered outputs
  logic             mem_req_q, mem_req_d;
  logic             write_en_q, write_en_d;
  logic [3:0]       wr_sel_q, wr_sel_d;
  logic [31:0]      data_q, data_d;
  logic             pc_we_q, pc_we_d;
  logic [31:0]      pc_q, pc_d;
  logic             sp_we_q, sp_we_d;
  logic [31:0]      sp_q, sp_d;
  logic             done_q, done_d;

  // Next target register among the remaining list bits
  logic [IW-1:0]    enc_idx;
  logic             enc_valid;

  lsb_enc #(.N(NREGS), .IW(IW)) u_lsb_enc (
    .vec   (list_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Number of words the request will transfer
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] start_cnt;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      pop_cnt = pop_cnt + CW'(reg_list_i[i]);
    end
    start_cnt = pop_cnt + CW'(pc_bit_i);
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    pc_pend_d  = pc_pend_q;
    addr_d     = addr_q;
    base_d     = base_q;
    sp_upd_d   = sp_upd_q;
    cnt_d      = cnt_q;
    mem_req_d  = 1'b0;
    write_en_d = 1'b0;
    wr_sel_d   = wr_sel_q;
    data_d     = data_q;
    pc_we_d    = 1'b0;
    pc_d       = pc_q;
    sp_we_d    = 1'b0;
    sp_d       = sp_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          list_d    = reg_list_i;
          pc_pend_d = pc_bit_i;
          addr_d    = {base_i[31:2], 2'b00};
          base_d    = {base_i[31:2], 2'b00};
          sp_upd_d  = sp_update_i;
          cnt_d     = start_cnt;
          state_d   = (start_cnt != '0) ? LOAD : FIN;
        end
      end

      LOAD: begin
        if (mem_ack_i) begin
          if (enc_valid) begin
            write_en_d = 1'b1;
            wr_sel_d   = 4'(enc_idx);
            data_d     = mem_rdata_i;
            // Clearing the lowest set bit retires exactly the encoded target.
            list_d     = list_q & (list_q - LIST_ONE);
          end else begin
            // All low registers done; this beat is the PC load.
            pc_we_d   = 1'b1;
            pc_d      = mem_rdata_i;
            wr_sel_d  = REG_PC;
            pc_pend_d = 1'b0;
          end
          addr_d = addr_q + 32'(WORD_BYTES);
          if ((list_d == '0) && !pc_pend_d) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    mem_req_d = (state_d == LOAD);
    if (state_d == FIN) begin
      done_d = 1'b1;
      if (sp_upd_d) begin
        sp_we_d = 1'b1;
        sp_d    = base_d + (32'(cnt_d) * 32'(WORD_BYTES));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      list_q     <= '0;
      pc_pend_q  <= 1'b0;
      addr_q     <= '0;
      base_q     <= '0;
      sp_upd_q   <= 1'b0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      write_en_q <= 1'b0;
      wr_sel_q   <= '0;
      data_q     <= '0;
      pc_we_q    <= 1'b0;
      pc_q       <= '0;
      sp_we_q    <= 1'b0;
      sp_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      pc_pend_q  <= pc_pend_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      sp_upd_q   <= sp_upd_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      write_en_q <= write_en_d;
      wr_sel_q   <= wr_sel_d;
      data_q     <= data_d;
      pc_we_q    <= pc_we_d;
      pc_q       <= pc_d;
      sp_we_q    <= sp_we_d;
      sp_q       <= sp_d;
      done_q     <= done_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = addr_q;
  assign write_en_o    = write_en_q;
  assign wr_select_o   = wr_sel_q;
  assign data_o        = data_q;
  assign sp_write_en_o = sp_we_q;
  assign sp_o          = sp_q;
  assign pc_we_o       = pc_we_q;
  assign pc_o          = pc_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer: directed scenarios plus a short
// random run. Expected beats are queued when a request is driven and popped
// when the DUT produces the matching strobe.
module tb_pop_sequencer;
  import regfile_pkg::*;

  localparam int NREGS = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic             start_i;
  logic [NREGS-1:0] reg_list_i;
  logic             pc_bit_i;
  logic [31:0]      base_i;
  logic             sp_update_i;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic             mem_ack_i;
  logic [31:0]      mem_rdata_i;
  logic             write_en_o;
  logic [3:0]       wr_select_o;
  logic [31:0]      data_o;
  logic             sp_write_en_o;
  logic [31:0]      sp_o;
  logic             pc_we_o;
  logic [31:0]      pc_o;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       state_o;

  pop_sequencer #(.NREGS(NREGS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .reg_list_i    (reg_list_i),
    .pc_bit_i      (pc_bit_i),
    .base_i        (base_i),
    .sp_update_i   (sp_update_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .write_en_o    (write_en_o),
    .wr_select_o   (wr_select_o),
    .data_o        (data_o),
    .sp_write_en_o (sp_write_en_o),
    .sp_o          (sp_o),
    .pc_we_o       (pc_we_o),
    .pc_o          (pc_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  // Scoreboard
  logic [51:0] exp_wr_q[$];   // {cycle16, sel4, data32}
  logic [47:0] exp_pc_q[$];   // {cycle16, data32}
  logic [47:0] exp_sp_q[$];   // {cycle16, sp32}
  logic [31:0] exp_addr_q[$]; // addresses still to be acked

  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_cyc  = 0;
  int   exp_done_rel = 0;
  int   ack_dly  = 0;
  int   wait_cnt = 0;
  logic op_active = 1'b0;
  logic seen_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: 0x2000 holds 0x101, everything else is address-derived.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h0000_0101;
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // One cycle: wait for negedge, check outputs, drive the memory responder.
  task automatic tick();
    int rel;
    logic [51:0] ew;
    logic [47:0] ep;
    @(negedge clk);
    rel = cyc - acc_cyc;
    if (op_active) check("busy", 64'(busy_o), 64'((rel >= 1) && (rel <= exp_done_rel)));
    else           check("busy_idle", 64'(busy_o), 64'd0);

    if (write_en_o) begin
      if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(write_en_o), 64'd0);
      else begin
        ew = exp_wr_q.pop_front();
        check("wr_cycle", 64'(rel), 64'(ew[51:36]));
        check("wr_sel",   64'(wr_select_o), 64'(ew[35:32]));
        check("wr_data",  64'(data_o), 64'(ew[31:0]));
      end
    end
    if (pc_we_o) begin
      if (exp_pc_q.size() == 0) check("pc_unexpected", 64'(pc_we_o), 64'd0);
      else begin
        ep = exp_pc_q.pop_front();
        check("pc_cycle", 64'(rel), 64'(ep[47:32]));
        check("pc_data",  64'(pc_o), 64'(ep[31:0]));
      end
    end
    if (sp_write_en_o) begin
      if (exp_sp_q.size() == 0) check("sp_unexpected", 64'(sp_write_en_o), 64'd0);
      else begin
        ep = exp_sp_q.pop_front();
        check("sp_cycle", 64'(rel), 64'(ep[47:32]));
        check("sp_value", 64'(sp_o), 64'(ep[31:0]));
      end
    end
    if (done_o) begin
      if (!op_active || seen_done) check("done_unexpected", 64'(done_o), 64'd0);
      else begin
        seen_done = 1'b1;
        check("done_cycle", 64'(rel), 64'(exp_done_rel));
        check("state_fin", 64'(state_o), 64'(FIN));
      end
    end

    if (mem_req_o) begin
      if (exp_addr_q.size() == 0) begin
        check("req_unexpected", 64'(mem_req_o), 64'd0);
        mem_ack_i = 1'b0;
      end else begin
        check("req_addr", 64'(mem_addr_o), 64'(exp_addr_q[0]));
        if (wait_cnt == ack_dly) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_fn(mem_addr_o);
          void'(exp_addr_q.pop_front());
          wait_cnt = 0;
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end
    end else begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},  64'(mem_req_o), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    check({tag, "_write_en"}, 64'(write_en_o), 64'd0);
    check({tag, "_wr_sel"},   64'(wr_select_o), 64'd0);
    check({tag, "_data"},     64'(data_o), 64'd0);
    check({tag, "_sp_we"},    64'(sp_write_en_o), 64'd0);
    check({tag, "_sp"},       64'(sp_o), 64'd0);
    check({tag, "_pc_we"},    64'(pc_we_o), 64'd0);
    check({tag, "_pc"},       64'(pc_o), 64'd0);
    check({tag, "_busy"},     64'(busy_o), 64'd0);
    check({tag, "_done"},     64'(done_o), 64'd0);
    check({tag, "_state"},    64'(state_o), 64'(IDLE));
  endtask

  // Queue the expected beats, drive the request and advance into cycle 1.
  task automatic start_op(input logic [7:0] list, input logic pc, input logic [31:0] base,
                          input logic spu, input int dly);
    logic [31:0] a;
    int n;
    int rel_w;
    a = {base[31:2], 2'b00};
    n = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (list[i]) begin
        rel_w = 1 + n * (dly + 1) + dly + 1;
        exp_addr_q.push_back(a);
        exp_wr_q.push_back({16'(rel_w), 4'(i), mem_fn(a)});
        a = a + 32'd4;
        n++;
      end
    end
    if (pc) begin
      rel_w = 1 + n * (dly + 1) + dly + 1;
      exp_addr_q.push_back(a);
      exp_pc_q.push_back({16'(rel_w), mem_fn(a)});
      n++;
    end
    exp_done_rel = 1 + n * (dly + 1);
    if (spu) exp_sp_q.push_back({16'(exp_done_rel), {base[31:2], 2'b00} + 32'(n) * 32'd4});
    ack_dly   = dly;
    wait_cnt  = 0;
    seen_done = 1'b0;
    start_i     = 1'b1;
    reg_list_i  = list;
    pc_bit_i    = pc;
    base_i      = base;
    sp_update_i = spu;
    acc_cyc   = cyc;
    op_active = 1'b1;
    tick();
    // Scramble request inputs: the DUT must use only what it sampled.
    start_i     = 1'b0;
    reg_list_i  = 8'($urandom);
    pc_bit_i    = 1'($urandom_range(0, 1));
    base_i      = $urandom;
    sp_update_i = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_op(input logic poke);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      tick();
      if (poke && (cyc - acc_cyc == 2)) begin
        start_i     = 1'b1;
        reg_list_i  = 8'hFF;
        pc_bit_i    = 1'b1;
        base_i      = 32'h0000_0000;
        sp_update_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
    if (!seen_done) check("done_timeout", 64'(seen_done), 64'd1);
    start_i = 1'b0;
    tick();
    op_active = 1'b0;
    check("wr_left",   64'(exp_wr_q.size()), 64'd0);
    check("pc_left",   64'(exp_pc_q.size()), 64'd0);
    check("sp_left",   64'(exp_sp_q.size()), 64'd0);
    check("addr_left", 64'(exp_addr_q.size()), 64'd0);
    exp_wr_q.delete();
    exp_pc_q.delete();
    exp_sp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic run_op(input logic [7:0] list, input logic pc, input logic [31:0] base,
                        input logic spu, input int dly, input logic poke);
    start_op(list, pc, base, spu, dly);
    finish_op(poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_i     = 1'b0;
    reg_list_i  = '0;
    pc_bit_i    = 1'b0;
    base_i      = '0;
    sp_update_i = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    tick();
    tick();

    // Three registers, zero wait states
    run_op(8'b1000_0101, 1'b0, 32'h0000_1FF0, 1'b1, 0, 1'b0);
    // Same list, three wait states per beat
    run_op(8'b1000_0101, 1'b0, 32'h0000_1FF0, 1'b1, 3, 1'b0);
    // PC only
    run_op(8'h00, 1'b1, 32'h0000_2000, 1'b1, 0, 1'b0);
    // Empty request, unaligned base
    run_op(8'h00, 1'b0, 32'h4000_0003, 1'b1, 0, 1'b0);
    run_op(8'h00, 1'b0, 32'h0000_5000, 1'b0, 0, 1'b0);

    // Reset after the first beat of a four-register list
    start_op(8'b0011_1100, 1'b0, 32'h0000_3000, 1'b1, 0);
    tick();
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    op_active = 1'b0;
    exp_wr_q.delete();
    exp_pc_q.delete();
    exp_sp_q.delete();
    exp_addr_q.delete();
    wait_cnt = 0;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0_0001;
    tick();
    tick();
    tick();
    run_op(8'b0011_1100, 1'b0, 32'h0000_3000, 1'b1, 0, 1'b0);

    // Start while busy, wrap past the top of memory, no SP writeback
    run_op(8'b0001_0010, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 1'b1);

    // Random requests
    for (int k = 0; k < 8; k++) begin
      run_op(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
